// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch-stage types and constants
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int          PC_INC    = 4;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory request/acknowledge bus
interface fetch_unit_if #(
  parameter int ADDR_W = 64
);

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_skid_buffer.sv
// rtl/fetch_skid_buffer.sv - one-entry parking slot for an instruction fetched during stall
module fetch_skid_buffer
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              load,
  input  logic              drain,
  input  logic              clear,
  input  logic [31:0]       load_instr,
  input  logic [ADDR_W-1:0] load_pc,
  output logic              full,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] pc
);

  logic              full_q, full_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] pc_q, pc_d;

  always_comb begin
    full_d  = full_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (clear || drain) begin
      full_d = 1'b0;
    end else if (load) begin
      full_d  = 1'b1;
      instr_d = load_instr;
      pc_d    = load_pc;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      full_q  <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
    end else begin
      full_q  <= full_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign full  = full_q;
  assign instr = instr_q;
  assign pc    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage feeding IF/ID; FETCH_PERF_EN adds perf counters
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              stall_if,
  input  logic              flush_if,
  input  logic [ADDR_W-1:0] redirect_pc,
  fetch_unit_if.master      imem,
  output logic              if_id_valid,
  output logic [31:0]       if_id_instr,
  output logic [ADDR_W-1:0] if_id_pc
`ifdef FETCH_PERF_EN
  ,output logic [31:0]      perf_fetched
  ,output logic [31:0]      perf_killed
`endif
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] drain_addr_q, drain_addr_d;
  logic              valid_q, valid_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] if_id_pc_q, if_id_pc_d;

  logic              skid_load, skid_drain, skid_clear, skid_full;
  logic [31:0]       skid_instr;
  logic [ADDR_W-1:0] skid_pc;
  logic [ADDR_W-1:0] redirect_aligned;
  logic [ADDR_W-1:0] pc_next;

  assign redirect_aligned = redirect_pc & ~ADDR_W'(3);
  assign pc_next          = pc_q + ADDR_W'(PC_INC);

  fetch_skid_buffer #(.ADDR_W(ADDR_W)) u_skid (
    .clk        (clk),
    .arst       (arst),
    .load       (skid_load),
    .drain      (skid_drain),
    .clear      (skid_clear),
    .load_instr (imem.imem_rdata),
    .load_pc    (pc_q),
    .full       (skid_full),
    .instr      (skid_instr),
    .pc         (skid_pc)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    valid_d      = valid_q;
    instr_d      = instr_q;
    if_id_pc_d   = if_id_pc_q;
    skid_load    = 1'b0;
    skid_drain   = 1'b0;
    skid_clear   = 1'b0;
    unique case (state_q)
      REQ: begin
        if (imem.imem_ack) begin
          if (flush_if) begin
            pc_d    = redirect_aligned;
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
          end else if (stall_if) begin
            skid_load = 1'b1;
            state_d   = HOLD;
          end else begin
            valid_d    = 1'b1;
            instr_d    = imem.imem_rdata;
            if_id_pc_d = pc_q;
            pc_d       = pc_next;
          end
        end else if (flush_if) begin
          // The request already seen by memory must still be acked, so keep its address.
          pc_d         = redirect_aligned;
          drain_addr_d = pc_q;
          valid_d      = 1'b0;
          instr_d      = NOP_INSTR;
          state_d      = DRAIN;
        end else if (!stall_if) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
        end
      end
      DRAIN: begin
        if (flush_if) begin
          pc_d = redirect_aligned;
        end
        if (flush_if || !stall_if) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
        end
        if (imem.imem_ack) begin
          state_d = REQ;
        end
      end
      HOLD: begin
        if (flush_if) begin
          skid_clear = 1'b1;
          pc_d       = redirect_aligned;
          valid_d    = 1'b0;
          instr_d    = NOP_INSTR;
          state_d    = REQ;
        end else if (!stall_if) begin
          skid_drain = 1'b1;
          valid_d    = skid_full;
          instr_d    = skid_instr;
          if_id_pc_d = skid_pc;
          pc_d       = pc_next;
          state_d    = REQ;
        end
      end
      default: state_d = REQ;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q      <= REQ;
      pc_q         <= RESET_PC;
      drain_addr_q <= '0;
      valid_q      <= 1'b0;
      instr_q      <= NOP_INSTR;
      if_id_pc_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      if_id_pc_q   <= if_id_pc_d;
    end
  end

  // Request drops immediately with reset so nothing is issued while arst is held.
  assign imem.imem_req  = ~arst & (state_q != HOLD);
  assign imem.imem_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;

  assign if_id_valid = valid_q;
  assign if_id_instr = instr_q;
  assign if_id_pc    = if_id_pc_q;

`ifdef FETCH_PERF_EN
  logic [31:0] fetched_q, fetched_d;
  logic [31:0] killed_q, killed_d;

  always_comb begin
    fetched_d = fetched_q;
    killed_d  = killed_q;
    if (((state_q == REQ) && imem.imem_ack && !flush_if && !stall_if) ||
        ((state_q == HOLD) && !flush_if && !stall_if)) begin
      fetched_d = fetched_q + 32'd1;
    end
    if (imem.imem_ack && ((state_q == DRAIN) || ((state_q == REQ) && flush_if))) begin
      killed_d = killed_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      fetched_q <= '0;
      killed_q  <= '0;
    end else begin
      fetched_q <= fetched_d;
      killed_q  <= killed_d;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_killed  = killed_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit (FETCH_PERF_EN optional)
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int AW = 64;

  logic          clk = 1'b0;
  logic          arst = 1'b1;
  logic          stall = 1'b0;
  logic          flush = 1'b0;
  logic          ack = 1'b0;
  logic [AW-1:0] redir = '0;

  logic          if_id_valid;
  logic [31:0]   if_id_instr;
  logic [AW-1:0] if_id_pc;
`ifdef FETCH_PERF_EN
  logic [31:0]   perf_fetched, perf_killed;
  logic [31:0]   killed_before;
`endif

  fetch_unit_if #(.ADDR_W(AW)) bus ();

  assign bus.imem_ack   = ack;
  assign bus.imem_rdata = 32'hC0DE_0000 | (32'(bus.imem_addr) & 32'h0000_FFFF);

  fetch_unit #(.ADDR_W(AW), .RESET_PC('0)) dut (
    .clk         (clk),
    .arst        (arst),
    .stall_if    (stall),
    .flush_if    (flush),
    .redirect_pc (redir),
    .imem        (bus),
    .if_id_valid (if_id_valid),
    .if_id_instr (if_id_instr),
    .if_id_pc    (if_id_pc)
`ifdef FETCH_PERF_EN
    ,.perf_fetched (perf_fetched)
    ,.perf_killed  (perf_killed)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [31:0]   instr;
    logic [AW-1:0] pc;
  } ifid_t;

  ifid_t         exp_q[$];
  logic [AW-1:0] addr_q[$];

  task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  logic          prev_valid = 1'b0;
  logic [AW-1:0] prev_pc = '0;

  always @(negedge clk) begin
    if (bus.imem_req && ack) begin
      if (addr_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL imem_addr_unexpected: got %0h want none", bus.imem_addr);
      end else begin
        check("imem_addr", bus.imem_addr, addr_q.pop_front());
      end
    end
    if (if_id_valid && (!prev_valid || if_id_pc != prev_pc)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL ifid_unexpected: got pc %0h instr %0h want none", if_id_pc, if_id_instr);
      end else begin
        ifid_t e;
        e = exp_q.pop_front();
        check("ifid_instr", AW'(if_id_instr), AW'(e.instr));
        check("ifid_pc", if_id_pc, e.pc);
      end
    end
    prev_valid <= if_id_valid;
    prev_pc    <= if_id_pc;
  end

  task automatic cyc(input logic a, input logic s, input logic f, input logic [AW-1:0] r);
    ack = a; stall = s; flush = f; redir = r;
    @(posedge clk);
    #1;
    ack = 1'b0; stall = 1'b0; flush = 1'b0;
  endtask

  task automatic expect_fetch(input logic [AW-1:0] a, input logic deliver);
    addr_q.push_back(a);
    if (deliver) exp_q.push_back({32'hC0DE_0000 | (32'(a) & 32'h0000_FFFF), a});
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_req", AW'(bus.imem_req), 0);
    check("reset_valid", AW'(if_id_valid), 0);
    check("reset_instr", AW'(if_id_instr), AW'(NOP_INSTR));
    check("reset_pc", if_id_pc, 0);
    arst = 1'b0;
    #1;
    check("release_req", AW'(bus.imem_req), 1);
    check("release_addr", bus.imem_addr, 0);

    // sequential fetch, ack every cycle
    expect_fetch(64'h0, 1); cyc(1, 0, 0, 0);
    check("first_valid", AW'(if_id_valid), 1);
    expect_fetch(64'h4, 1); cyc(1, 0, 0, 0);
    // ack at 0x8 under a 3-cycle stall
    expect_fetch(64'h8, 1); cyc(1, 1, 0, 0);
    check("hold_req", AW'(bus.imem_req), 0);
    check("hold_ifid_pc", if_id_pc, 64'h4);
    cyc(0, 1, 0, 0);
    check("hold_req2", AW'(bus.imem_req), 0);
    cyc(0, 1, 0, 0);
    check("hold_ifid_pc3", if_id_pc, 64'h4);
    cyc(0, 0, 0, 0);
    check("unstall_ifid_pc", if_id_pc, 64'h8);
    check("unstall_req", AW'(bus.imem_req), 1);
    check("unstall_addr", bus.imem_addr, 64'hC);

    // flush with ack in the same cycle
    expect_fetch(64'hC, 0); cyc(1, 0, 1, 64'h100);
    check("flush_addr", bus.imem_addr, 64'h100);
    check("flush_bubble", AW'(if_id_valid), 0);
    check("flush_nop", AW'(if_id_instr), AW'(NOP_INSTR));
    expect_fetch(64'h100, 1); cyc(1, 0, 0, 0);
    expect_fetch(64'h104, 1); cyc(1, 0, 0, 0);
    expect_fetch(64'h108, 0); cyc(1, 0, 1, 64'h10);
    check("redir_10", bus.imem_addr, 64'h10);

    // flush while 0x10 waits three cycles
    cyc(0, 0, 1, 64'h200);
    check("drain_addr1", bus.imem_addr, 64'h10);
    check("drain_req", AW'(bus.imem_req), 1);
    cyc(0, 0, 0, 0);
    check("drain_addr2", bus.imem_addr, 64'h10);
    cyc(0, 0, 0, 0);
    check("drain_addr3", bus.imem_addr, 64'h10);
`ifdef FETCH_PERF_EN
    killed_before = perf_killed;
`endif
    expect_fetch(64'h10, 0); cyc(1, 0, 0, 0);
    check("post_drain_addr", bus.imem_addr, 64'h200);
    check("post_drain_bubble", AW'(if_id_valid), 0);
`ifdef FETCH_PERF_EN
    check("perf_killed_inc", AW'(perf_killed), AW'(killed_before + 32'd1));
`endif
    expect_fetch(64'h200, 1); cyc(1, 0, 0, 0);

    // stall parks 0x204, then flush and stall together in HOLD
    expect_fetch(64'h204, 0); cyc(1, 1, 0, 0);
    check("hold2_req", AW'(bus.imem_req), 0);
    check("hold2_ifid_pc", if_id_pc, 64'h200);
    cyc(0, 1, 1, 64'h300);
    check("holdflush_req", AW'(bus.imem_req), 1);
    check("holdflush_addr", bus.imem_addr, 64'h300);
    check("holdflush_bubble", AW'(if_id_valid), 0);
    expect_fetch(64'h300, 1); cyc(1, 0, 0, 0);

    // redirect low bits ignored, then pc wraps past the top of the space
    expect_fetch(64'h304, 0); cyc(1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    check("align_addr", bus.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    expect_fetch(64'hFFFF_FFFF_FFFF_FFFC, 1); cyc(1, 0, 0, 0);
    check("wrap_addr", bus.imem_addr, 64'h0);
    expect_fetch(64'h0, 1); cyc(1, 0, 0, 0);
    check("wait_addr", bus.imem_addr, 64'h4);
    cyc(0, 0, 0, 0);

    // reset mid-wait
    arst = 1'b1;
    #1;
    check("midrst_req", AW'(bus.imem_req), 0);
    check("midrst_valid", AW'(if_id_valid), 0);
    check("midrst_instr", AW'(if_id_instr), AW'(NOP_INSTR));
    check("midrst_pc", if_id_pc, 0);
`ifdef FETCH_PERF_EN
    check("midrst_killed", AW'(perf_killed), 0);
`endif
    @(posedge clk);
    #1;
    arst = 1'b0;
    #1;
    check("rerelease_req", AW'(bus.imem_req), 1);
    check("rerelease_addr", bus.imem_addr, 64'h0);
    expect_fetch(64'h0, 1); cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check("exp_left", AW'(exp_q.size()), 0);
    check("addr_left", AW'(addr_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
